// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the hard-wired zero register index.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned ST_W  = 2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [ST_W-1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERR      = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline side,
// slave = hazard_ctrl.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_write_addr;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             err_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pipe_hold;
    logic             err_timeout;
    logic [ST_W-1:0]  state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_write_addr,
               ex_branch_taken, mem_busy, err_clr,
        input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
               err_timeout, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_write_addr,
               ex_branch_taken, mem_busy, err_clr,
        output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
               err_timeout, state
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the ID
// instruction. Purely combinational; also used by the forwarding unit.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_addr,
    output logic             load_use_c
);

    logic rs1_hit_c;
    logic rs2_hit_c;

    assign rs1_hit_c  = (ex_write_addr == id_rs1);
    assign rs2_hit_c  = id_uses_rs2 && (ex_write_addr == id_rs2);
    assign load_use_c = ex_mem_read && (ex_write_addr != REG_ZERO) && (rs1_hit_c || rs2_hit_c);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/hold sequencing for the 5-stage core with memory-wait timeout.
// Optional perf counters behind HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned TO_W        = 8,
    parameter int unsigned MEM_TIMEOUT = 200
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W      = 32
`endif
) (
    input  logic              clock,
    input  logic              reset,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_events,
`endif
    hazard_ctrl_if.slave      hz
);

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic load_use_c;
    logic run_flow_c;
    logic br_acc_c;
    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c, pipe_hold_c;

    hazard_detect u_detect (
        .id_rs1        (hz.id_rs1),
        .id_rs2        (hz.id_rs2),
        .id_uses_rs2   (hz.id_uses_rs2),
        .ex_mem_read   (hz.ex_mem_read),
        .ex_write_addr (hz.ex_write_addr),
        .load_use_c    (load_use_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state plus hold/flow decision; run_flow_c means hazards apply this cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        run_flow_c = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (hz.mem_busy) begin
                    state_d = HZ_MEM_WAIT;
                    cnt_d   = TO_W'(1);
                end else begin
                    run_flow_c = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                if (!hz.mem_busy) begin
                    state_d    = HZ_RUN;
                    cnt_d      = '0;
                    run_flow_c = 1'b1;
                end else if ((MEM_TIMEOUT != 0) && (32'(cnt_q) == MEM_TIMEOUT)) begin
                    state_d = HZ_ERR;
                    err_d   = 1'b1;
                end else if (cnt_q != {TO_W{1'b1}}) begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            HZ_ERR: begin
                if (hz.err_clr) begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d    = HZ_RUN;
                cnt_d      = '0;
                run_flow_c = 1'b1;
            end
        endcase
    end

    // Pipeline controls; a taken branch squashes the ID instruction so it beats load-use.
    always_comb begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        pipe_hold_c  = 1'b0;
        br_acc_c     = 1'b0;
        if (!reset) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (!run_flow_c) begin
            pipe_hold_c = 1'b1;
        end else if (hz.ex_branch_taken) begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            br_acc_c     = 1'b1;
        end else if (load_use_c) begin
            idex_flush_c = 1'b1;
        end else begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_flush  = idex_flush_c;
    assign hz.pipe_hold   = pipe_hold_c;
    assign hz.err_timeout = err_q;
    assign hz.state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (!pc_write_c && (perf_stall_cycles != {PERF_W{1'b1}}))
                perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
            if (br_acc_c && (perf_flush_events != {PERF_W{1'b1}}))
                perf_flush_events <= perf_flush_events + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: consecutive busy-cycle streak and sticky error.
    int          m_streak = 0;
    bit          m_err    = 1'b0;
    int unsigned m_stall  = 0;
    int unsigned m_flush  = 0;

    hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;
`endif

    hazard_ctrl #(
        .TO_W        (8),
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events),
`endif
        .hz                (hz)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0;
        m_err    = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    // Compare current outputs with the model, then advance the model over the coming edge.
    task automatic eval_cycle();
        logic lu, hold, br;
        logic e_pc, e_ifw, e_iff, e_idf, e_ph;
        logic [1:0] e_st;
        lu = hz.ex_mem_read && (hz.ex_write_addr != 5'd0) &&
             ((hz.ex_write_addr == hz.id_rs1) ||
              (hz.id_uses_rs2 && (hz.ex_write_addr == hz.id_rs2)));
        br   = hz.ex_branch_taken;
        hold = m_err || hz.mem_busy;
        if (!reset)      {e_pc, e_ifw, e_iff, e_idf, e_ph} = 5'b00110;
        else if (hold)   {e_pc, e_ifw, e_iff, e_idf, e_ph} = 5'b00001;
        else if (br)     {e_pc, e_ifw, e_iff, e_idf, e_ph} = 5'b11110;
        else if (lu)     {e_pc, e_ifw, e_iff, e_idf, e_ph} = 5'b00010;
        else             {e_pc, e_ifw, e_iff, e_idf, e_ph} = 5'b11000;
        e_st = m_err ? 2'd2 : (m_streak > 0 ? 2'd1 : 2'd0);

        check("pc_write",    32'(hz.pc_write),    32'(e_pc));
        check("ifid_write",  32'(hz.ifid_write),  32'(e_ifw));
        check("ifid_flush",  32'(hz.ifid_flush),  32'(e_iff));
        check("idex_flush",  32'(hz.idex_flush),  32'(e_idf));
        check("pipe_hold",   32'(hz.pipe_hold),   32'(e_ph));
        check("err_timeout", 32'(hz.err_timeout), 32'(m_err));
        check("state",       32'(hz.state),       32'(e_st));
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall",  perf_stall_cycles,   m_stall);
        check("perf_flush",  perf_flush_events,   m_flush);
`endif
        if (reset) begin
            if (!e_pc) m_stall++;
            if (!hold && br) m_flush++;
            if (m_err) begin
                if (hz.err_clr) begin
                    m_err    = 1'b0;
                    m_streak = 0;
                end
            end else if (hz.mem_busy) begin
                m_streak++;
                if (m_streak == int'(TIMEOUT) + 1) m_err = 1'b1;
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic run_cycle(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                             input logic mr, input logic [4:0] wa, input logic bt,
                             input logic bz, input logic cl);
        @(posedge clock);
        #1;
        hz.id_rs1          = r1;
        hz.id_rs2          = r2;
        hz.id_uses_rs2     = u2;
        hz.ex_mem_read     = mr;
        hz.ex_write_addr   = wa;
        hz.ex_branch_taken = bt;
        hz.mem_busy        = bz;
        hz.err_clr         = cl;
        #1;
        eval_cycle();
    endtask

    task automatic idle_cycle();
        run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        eval_cycle();
    endtask

    initial begin
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_uses_rs2 = 1'b0; hz.ex_mem_read = 1'b0;
        hz.ex_write_addr = '0; hz.ex_branch_taken = 1'b0; hz.mem_busy = 1'b0; hz.err_clr = 1'b0;

        // Reset values, including busy/hazard inputs while in reset
        run_cycle(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        release_reset();
        idle_cycle();

        // Load-use on rs1, then load gone
        run_cycle(5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        run_cycle(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        // Register zero never stalls; rs2 gated by id_uses_rs2
        run_cycle(5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        run_cycle(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        run_cycle(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        // Branch overrides load-use
        run_cycle(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        idle_cycle();

        // Memory wait for 3 cycles, release with a pending load-use
        repeat (3) run_cycle(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        run_cycle(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        // Timeout: stuck busy, hold persists after busy drops, err_clr ignored until ERR
        run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        repeat (6) run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        repeat (2) run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Reset asserted mid-wait takes effect immediately
        repeat (3) run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        eval_cycle();
        run_cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        release_reset();

        // Random traffic with alternating light/heavy memory contention
        for (int blk = 0; blk < 40; blk++) begin
            int unsigned bias;
            bias = (blk % 2 == 0) ? 20 : 85;
            for (int i = 0; i < 50; i++) begin
                run_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 99) < 20),
                          1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) < 10));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
